// File: rtl/demux1to4_reg.sv
`default_nettype none
// ============================================================================
// demux1to4_reg : registered 1-to-4 demux, one holding register per lane
// Revision      : 1.0
// ============================================================================
module demux1to4_reg #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [7:0]         xfer_count
);

  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [3:0]            valid_q, valid_d;
  logic [7:0]            count_q, count_d;
  logic                  acc;

  // A full lane can still accept when its consumer drains it in the same cycle.
  assign in_ready = ~reset & (~valid_q[in_sel] | out_ready[in_sel]);
  assign acc      = in_valid & in_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~out_ready;
    count_d = count_q;
    if (acc) begin
      data_d[in_sel]  = in_data;
      valid_d[in_sel] = 1'b1;
      count_d         = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule
`default_nettype wire
